vram_console_ctrl: RTL and testbench
====================================

Name: vram_console_ctrl

Overview:
- Sequences writes into the text VRAM write port (port A) of the LCD text display.
- Arbitrates between two requesters: a raw CPU cell-write port and a terminal-style character stream.
- The character stream has cursor tracking, control codes, line wrap and hardware line/screen clear.
- Sits beside the LCD text display and drives its ram_ce/ram_addr/ram_data inputs. That port is clocked by clk_pix.

Parameters:
- CELLS, 750, cells per screen in every direction (50x15 or 30x25).
- BLANK, 8'h20, character code written by clear operations.

Ports:
- clk_pix  in  1  pixel clock; all logic, including the VRAM write port, runs on it.
- reset  in  1  asynchronous, active-low.
- direction  in  2  display rotation; bit0=0 selects 50 cols x 15 rows, bit0=1 selects 30 cols x 25 rows.
- attr  in  8  {bg,fg} attribute used for character-stream and clear writes.
- cpu_valid  in  1  CPU cell-write request.
- cpu_addr  in  12  CPU cell address.
- cpu_data  in  16  CPU cell value {attr,char}.
- cpu_ready  out  1  CPU transfer accepted when cpu_valid&cpu_ready.
- ch_valid  in  1  character-stream request.
- ch_data  in  8  character / control code.
- ch_ready  out  1  character accepted when ch_valid&ch_ready.
- clr_req  in  1  one-cycle pulse; requests a full clear and cursor home.
- busy  out  1  high in LCLR or FCLR.
- cur_col  out  6  cursor column.
- cur_row  out  5  cursor row.
- ram_ce  out  1  VRAM write enable.
- ram_addr  out  12  VRAM write address.
- ram_data  out  16  VRAM write data.

Behaviour:
- Reset (async, low):
  - State FCLR with clear index 0; cursor at 0,0; rr_last=CPU.
  - ram_ce=0, ram_addr=0, ram_data=0.
  - cpu_ready=0, ch_ready=0, busy=1.
  - A clear therefore follows every reset.
- States:
  - IDLE: arbitrate.
  - LCLR: clear the current row.
  - FCLR: clear the whole screen.
- Readies (combinational):
  - cpu_ready = IDLE & !(ch_valid & rr_last==CPU).
  - ch_ready = IDLE & !(cpu_valid & rr_last==CH).
  - Round-robin between CPU and character stream; rr_last updates on every accepted transfer.
  - A lone requester is granted every cycle.
- Write timing: ram_* are registered. A transfer or clear step in cycle N gives ram_ce=1 in cycle N+1 with the matching addr/data. ram_ce=0 otherwise.
- CPU write: ram_addr=cpu_addr and ram_data=cpu_data, passed unmodified. The cursor is unaffected.
- Character stream, by code:
  - 0x20-0x7E: write {attr,ch_data} at cursor address, then col+1. If col was cols-1, do a line advance.
  - 0x0A LF: line advance.
  - 0x0D CR: col=0.
  - 0x08 BS: col-1 if col>0, else no-op.
  - 0x0C FF: same as clr_req.
  - All other codes: consumed, no effect.
  - Control codes produce no VRAM write.
- Line advance: col=0; row+1, or row=0 if row==rows-1; then enter LCLR.
- Cursor address: kept as an incrementally updated linear register, row*cols+col, with no multiplier. Its row base advances by cols and wraps to 0.
- LCLR:
  - One write per cycle of {attr,BLANK} at rowbase+0 .. rowbase+cols-1.
  - Then IDLE; takes cols cycles.
- FCLR:
  - Write addresses 0..CELLS-1, then IDLE with cursor 0,0.
  - Takes CELLS cycles.
- Clear entry and precedence:
  - clr_req, or a change of direction[0], enters FCLR from any state.
  - It restarts from index 0 if FCLR is already active, and aborts any LCLR.
  - Taking effect in cycle N, the next cycle performs the index-0 write.
- direction[0] is registered; cols/rows are derived from the registered value.
- Simultaneous clr_req and an accepted transfer in the same cycle: the transfer's write still issues, then FCLR starts.

Decomposition:
- Shared package vram_console_pkg:
  - state enum {IDLE,LCLR,FCLR}.
  - Control-code constants.
  - COLS0/ROWS0=50/15 and COLS1/ROWS1=30/25.
- One sub-module, console_cursor:
  - Holds col, row, rowbase and linear address.
  - Commands: advance, CR, BS, line advance, home; takes cols/rows as inputs.
- Arbiter and clear sequencer stay in the top.

Test Plan:
- Reset release with direction=0 -> exactly 750 writes, addr 0..749, data {attr,0x20}; then busy=0 with cursor 0,0.
- direction=0, attr=8'h1F, stream "AB" -> writes (0,16'h1F41) and (1,16'h1F42); cur_col=2.
- Cursor col=49 row=14, char 'x' -> write at 749; cursor becomes 0,0; LCLR writes 0..49; ch_ready stays 0 for those 50 cycles.
- cpu_valid and ch_valid held high together -> accepts alternate CPU/CH each cycle; ram_ce continuous.
- Mid-LCLR, pulse clr_req -> LCLR aborts; FCLR writes from 0 to 749; cursor homes.
- Switch direction 0->1 -> full clear; then 31 printable chars put the cursor at row 1, col 1, with LCLR of addresses 30..59.

Source files
------------

// File: rtl/vram_console_ctrl_pkg.sv
// Shared constants and types for the VRAM console controller: sequencer states,
// control codes, screen geometries and the cursor command set.
package vram_console_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LCLR = 2'd1;
  localparam logic [1:0] ST_FCLR = 2'd2;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  localparam logic [7:0] CH_FIRST = 8'h20;
  localparam logic [7:0] CH_LAST  = 8'h7E;

  localparam logic [5:0] COLS0 = 6'd50;
  localparam logic [4:0] ROWS0 = 5'd15;
  localparam logic [5:0] COLS1 = 6'd30;
  localparam logic [4:0] ROWS1 = 5'd25;

  localparam logic RR_CPU = 1'b0;
  localparam logic RR_CH  = 1'b1;

  typedef enum logic [2:0] {
    CUR_NONE = 3'd0,
    CUR_ADV  = 3'd1,
    CUR_CR   = 3'd2,
    CUR_BS   = 3'd3,
    CUR_LINE = 3'd4,
    CUR_HOME = 3'd5
  } cur_cmd_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_FIRST) && (c <= CH_LAST);
  endfunction

endpackage

// File: rtl/vram_console_ctrl_if.sv
// Bundle of the controller's requester, status and VRAM write-port signals.
// The master side is the system (CPU, terminal, LCD); the slave side is the controller.
interface vram_console_ctrl_if;
  logic [1:0]  direction;
  logic [7:0]  attr;
  logic        cpu_valid;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_ready;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic        clr_req;
  logic        busy;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;
  logic        ram_ce;
  logic [11:0] ram_addr;
  logic [15:0] ram_data;

  modport master (
    output direction, attr, cpu_valid, cpu_addr, cpu_data, ch_valid, ch_data, clr_req,
    input  cpu_ready, ch_ready, busy, cur_col, cur_row, ram_ce, ram_addr, ram_data
  );

  modport slave (
    input  direction, attr, cpu_valid, cpu_addr, cpu_data, ch_valid, ch_data, clr_req,
    output cpu_ready, ch_ready, busy, cur_col, cur_row, ram_ce, ram_addr, ram_data
  );
endinterface

// File: rtl/vram_console_ctrl_cursor.sv
// Terminal cursor: column, row, row base and linear cell address, all kept
// incrementally so the cell address never needs a multiply.
module console_cursor
  import vram_console_pkg::*;
(
  input  logic        clk_pix,
  input  logic        reset,
  input  cur_cmd_e    cmd_i,
  input  logic [5:0]  cols_i,
  input  logic [4:0]  rows_i,
  output logic [5:0]  col_o,
  output logic [4:0]  row_o,
  output logic [11:0] rowbase_o,
  output logic [11:0] addr_o,
  output logic        eol_o
);

  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [11:0] base_q, base_d;
  logic [11:0] addr_q, addr_d;
  logic        last_col_s;
  logic        last_row_s;
  logic [4:0]  nrow_s;
  logic [11:0] nbase_s;

  assign last_col_s = (col_q == (cols_i - 6'd1));
  assign last_row_s = (row_q == (rows_i - 5'd1));
  assign nrow_s     = last_row_s ? 5'd0 : (row_q + 5'd1);
  assign nbase_s    = last_row_s ? 12'd0 : (base_q + {6'd0, cols_i});

  // Next cursor position for the command issued this cycle
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    addr_d = addr_q;
    case (cmd_i)
      CUR_ADV, CUR_LINE: begin
        if ((cmd_i == CUR_LINE) || last_col_s) begin
          col_d  = 6'd0;
          row_d  = nrow_s;
          base_d = nbase_s;
          addr_d = nbase_s;
        end else begin
          col_d  = col_q + 6'd1;
          addr_d = addr_q + 12'd1;
        end
      end
      CUR_CR: begin
        col_d  = 6'd0;
        addr_d = base_q;
      end
      CUR_BS: begin
        if (col_q != 6'd0) begin
          col_d  = col_q - 6'd1;
          addr_d = addr_q - 12'd1;
        end else begin
          col_d  = col_q;
          addr_d = addr_q;
        end
      end
      CUR_HOME: begin
        col_d  = 6'd0;
        row_d  = 5'd0;
        base_d = 12'd0;
        addr_d = 12'd0;
      end
      default: begin
        col_d  = col_q;
        row_d  = row_q;
        base_d = base_q;
        addr_d = addr_q;
      end
    endcase
  end

  // Cursor state registers
  always_ff @(posedge clk_pix or negedge reset) begin
    if (!reset) begin
      col_q  <= 6'd0;
      row_q  <= 5'd0;
      base_q <= 12'd0;
      addr_q <= 12'd0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
      addr_q <= addr_d;
    end
  end

  assign col_o     = col_q;
  assign row_o     = row_q;
  assign rowbase_o = base_q;
  assign addr_o    = addr_q;
  assign eol_o     = last_col_s;

endmodule

// File: rtl/vram_console.sv
// VRAM console write sequencer: round-robin arbitration between CPU cell writes and
// a terminal character stream, plus line-clear and full-screen-clear engines.
module vram_console_ctrl
  import vram_console_pkg::*;
#(
  parameter int unsigned CELLS = 750,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic                clk_pix,
  input  logic                reset,
  vram_console_ctrl_if.slave  bus
);

  localparam logic [9:0] IDX_LAST = 10'(CELLS - 32'd1);

  logic [1:0]  state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic        rr_last_q, rr_last_d;
  logic        dir_q;
  logic        ram_ce_q, ram_ce_d;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_data_q, ram_data_d;

  logic [5:0]  cols_s;
  logic [4:0]  rows_s;
  logic        idle_s;
  logic        cpu_ready_s, ch_ready_s;
  logic        cpu_fire_s, ch_fire_s;
  logic        printable_s;
  logic        clr_go_s;
  logic        fclr_done_s;
  logic        lclr_done_s;
  logic        line_adv_s;
  cur_cmd_e    cmd_s;
  logic [5:0]  cur_col_s;
  logic [4:0]  cur_row_s;
  logic [11:0] rowbase_s;
  logic [11:0] cur_addr_s;
  logic        eol_s;
  logic        unused_dir_s;

  assign unused_dir_s = bus.direction[1];

  assign cols_s = dir_q ? COLS1 : COLS0;
  assign rows_s = dir_q ? ROWS1 : ROWS0;
  assign idle_s = (state_q == ST_IDLE);

  // The requester served last yields only when the other one is also asking.
  assign cpu_ready_s = idle_s & ~(bus.ch_valid & (rr_last_q == RR_CPU));
  assign ch_ready_s  = idle_s & ~(bus.cpu_valid & (rr_last_q == RR_CH));
  assign cpu_fire_s  = bus.cpu_valid & cpu_ready_s;
  assign ch_fire_s   = bus.ch_valid & ch_ready_s;
  assign printable_s = is_printable(bus.ch_data);

  assign clr_go_s    = bus.clr_req | (bus.direction[0] ^ dir_q) |
                       (ch_fire_s & (bus.ch_data == CC_FF));
  assign fclr_done_s = (state_q == ST_FCLR) && (idx_q == IDX_LAST);
  assign lclr_done_s = (idx_q == ({4'd0, cols_s} - 10'd1));
  assign line_adv_s  = ch_fire_s & ((bus.ch_data == CC_LF) | (printable_s & eol_s));

  // Cursor command decode; a clear homes the cursor on entry and again on completion
  always_comb begin
    cmd_s = CUR_NONE;
    if (clr_go_s || fclr_done_s) begin
      cmd_s = CUR_HOME;
    end else if (ch_fire_s) begin
      if (printable_s) begin
        cmd_s = CUR_ADV;
      end else begin
        case (bus.ch_data)
          CC_LF:   cmd_s = CUR_LINE;
          CC_CR:   cmd_s = CUR_CR;
          CC_BS:   cmd_s = CUR_BS;
          default: cmd_s = CUR_NONE;
        endcase
      end
    end else begin
      cmd_s = CUR_NONE;
    end
  end

  console_cursor u_cursor (
    .clk_pix   (clk_pix),
    .reset     (reset),
    .cmd_i     (cmd_s),
    .cols_i    (cols_s),
    .rows_i    (rows_s),
    .col_o     (cur_col_s),
    .row_o     (cur_row_s),
    .rowbase_o (rowbase_s),
    .addr_o    (cur_addr_s),
    .eol_o     (eol_s)
  );

  // Sequencer next state: a clear request overrides everything and restarts at index 0
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_last_d = rr_last_q;
    if (cpu_fire_s) begin
      rr_last_d = RR_CPU;
    end else if (ch_fire_s) begin
      rr_last_d = RR_CH;
    end else begin
      rr_last_d = rr_last_q;
    end
    if (clr_go_s) begin
      state_d = ST_FCLR;
      idx_d   = 10'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (line_adv_s) begin
            state_d = ST_LCLR;
            idx_d   = 10'd0;
          end else begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
          end
        end
        ST_LCLR: begin
          if (lclr_done_s) begin
            state_d = ST_IDLE;
            idx_d   = 10'd0;
          end else begin
            idx_d   = idx_q + 10'd1;
          end
        end
        ST_FCLR: begin
          if (fclr_done_s) begin
            state_d = ST_IDLE;
            idx_d   = 10'd0;
          end else begin
            idx_d   = idx_q + 10'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 10'd0;
        end
      endcase
    end
  end

  // VRAM write for this cycle's transfer or clear step; it lands on the port next cycle
  always_comb begin
    ram_ce_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_fire_s) begin
          ram_ce_d   = 1'b1;
          ram_addr_d = bus.cpu_addr;
          ram_data_d = bus.cpu_data;
        end else if (ch_fire_s && printable_s) begin
          ram_ce_d   = 1'b1;
          ram_addr_d = cur_addr_s;
          ram_data_d = {bus.attr, bus.ch_data};
        end else begin
          ram_ce_d   = 1'b0;
        end
      end
      ST_LCLR: begin
        ram_ce_d   = 1'b1;
        ram_addr_d = rowbase_s + {2'b00, idx_q};
        ram_data_d = {bus.attr, BLANK};
      end
      ST_FCLR: begin
        ram_ce_d   = 1'b1;
        ram_addr_d = {2'b00, idx_q};
        ram_data_d = {bus.attr, BLANK};
      end
      default: begin
        ram_ce_d   = 1'b0;
      end
    endcase
  end

  // State, arbitration and VRAM port registers; reset lands in a full clear
  always_ff @(posedge clk_pix or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_FCLR;
      idx_q      <= 10'd0;
      rr_last_q  <= RR_CPU;
      dir_q      <= 1'b0;
      ram_ce_q   <= 1'b0;
      ram_addr_q <= 12'd0;
      ram_data_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rr_last_q  <= rr_last_d;
      dir_q      <= bus.direction[0];
      ram_ce_q   <= ram_ce_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign bus.cpu_ready = cpu_ready_s;
  assign bus.ch_ready  = ch_ready_s;
  assign bus.busy      = (state_q == ST_LCLR) || (state_q == ST_FCLR);
  assign bus.cur_col   = cur_col_s;
  assign bus.cur_row   = cur_row_s;
  assign bus.ram_ce    = ram_ce_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_data  = ram_data_q;

endmodule

// File: tb/tb_vram_console_ctrl.sv
// Self-checking bench for vram_console_ctrl: directed table, multi-cycle corner
// sequences and a randomized phase compared against a screen-image model.
module tb_vram_console_ctrl;

  logic clk_pix = 1'b0;
  logic reset;
  always #5 clk_pix = ~clk_pix;

  vram_console_ctrl_if bus();

  vram_console_ctrl #(.CELLS(750), .BLANK(8'h20)) dut (
    .clk_pix (clk_pix),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct packed { logic [11:0] a; logic [15:0] d; } wr_t;
  typedef struct {
    logic [7:0]  ch;
    bit          has_wr;
    logic [11:0] wa;
    logic [15:0] wd;
    int          nclr;
    int          cbase;
    int          col;
    int          row;
  } vec_t;

  wr_t         wq[$];
  logic [15:0] dut_scr [0:749];
  logic [15:0] exp_scr [0:749];
  int          total = 0;
  int          bad = 0;
  int          m_col, m_row, m_cols, m_rows;
  logic [7:0]  m_attr;
  vec_t        tbl [11];

  // Write-port monitor: logs every write and keeps an image of the screen
  always @(negedge clk_pix) begin
    if (reset && bus.ram_ce) begin
      wq.push_back({bus.ram_addr, bus.ram_data});
      if (bus.ram_addr < 12'd750) dut_scr[int'(bus.ram_addr)] <= bus.ram_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_pix);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #1;
    while (bus.busy && n < 3000) begin tick(); n++; end
    chk("idle_bound", n < 3000, 1);
    tick();
    tick();
  endtask

  task automatic send_ch(input logic [7:0] c);
    int n;
    n = 0;
    tick();
    bus.ch_valid = 1'b1;
    bus.ch_data = c;
    #1;
    while (!bus.ch_ready && n < 3000) begin tick(); n++; end
    chk("ch_accept_bound", n < 3000, 1);
    tick();
    bus.ch_valid = 1'b0;
  endtask

  task automatic cpu_wr(input logic [11:0] a, input logic [15:0] d);
    int n;
    n = 0;
    tick();
    bus.cpu_valid = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_data = d;
    #1;
    while (!bus.cpu_ready && n < 3000) begin tick(); n++; end
    chk("cpu_accept_bound", n < 3000, 1);
    tick();
    bus.cpu_valid = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input logic [11:0] a, input logic [15:0] d);
    wr_t w;
    if (wq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got no write want %0h:%0h", nm, a, d);
    end else begin
      w = wq.pop_front();
      chk(nm, {4'h0, w.a, w.d}, {4'h0, a, d});
    end
  endtask

  // Pops n writes and expects blanks at base..base+n-1
  task automatic chk_run(input string nm, input int base, input int n, input logic [7:0] at);
    int errs;
    wr_t w;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      if (wq.size() == 0) begin
        errs++;
      end else begin
        w = wq.pop_front();
        if (w.a !== 12'(base + i) || w.d !== {at, 8'h20}) errs++;
      end
    end
    chk(nm, errs, 0);
  endtask

  task automatic m_clear();
    for (int i = 0; i < 750; i++) exp_scr[i] = {m_attr, 8'h20};
    m_col = 0;
    m_row = 0;
  endtask

  task automatic m_line();
    m_col = 0;
    m_row = (m_row + 1) % m_rows;
    for (int j = 0; j < m_cols; j++) exp_scr[m_row * m_cols + j] = {m_attr, 8'h20};
  endtask

  task automatic m_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_scr[m_row * m_cols + m_col] = {m_attr, c};
      m_col++;
      if (m_col == m_cols) m_line();
    end else if (c == 8'h0A) begin
      m_line();
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (c == 8'h0C) begin
      m_clear();
    end
  endtask

  initial begin
    int n;
    logic [7:0] c;
    logic [11:0] ra;
    logic [15:0] rd;
    int sel;
    int mism;

    tbl[0]  = '{8'h41, 1'b1, 12'd0,  16'h1F41, 0,  0,   1, 0};
    tbl[1]  = '{8'h42, 1'b1, 12'd1,  16'h1F42, 0,  0,   2, 0};
    tbl[2]  = '{8'h0D, 1'b0, 12'd0,  16'h0000, 0,  0,   0, 0};
    tbl[3]  = '{8'h08, 1'b0, 12'd0,  16'h0000, 0,  0,   0, 0};
    tbl[4]  = '{8'h43, 1'b1, 12'd0,  16'h1F43, 0,  0,   1, 0};
    tbl[5]  = '{8'h08, 1'b0, 12'd0,  16'h0000, 0,  0,   0, 0};
    tbl[6]  = '{8'h7F, 1'b0, 12'd0,  16'h0000, 0,  0,   0, 0};
    tbl[7]  = '{8'h01, 1'b0, 12'd0,  16'h0000, 0,  0,   0, 0};
    tbl[8]  = '{8'h0A, 1'b0, 12'd0,  16'h0000, 50, 50,  0, 1};
    tbl[9]  = '{8'h7E, 1'b1, 12'd50, 16'h1F7E, 0,  0,   1, 1};
    tbl[10] = '{8'h0A, 1'b0, 12'd0,  16'h0000, 50, 100, 0, 2};

    reset = 1'b0;
    bus.direction = 2'b00;
    bus.attr = 8'h1F;
    bus.cpu_valid = 1'b1;
    bus.cpu_addr = 12'd5;
    bus.cpu_data = 16'h1234;
    bus.ch_valid = 1'b1;
    bus.ch_data = 8'h41;
    bus.clr_req = 1'b0;
    tick();
    tick();
    chk("rst_ram_ce", bus.ram_ce, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_data", bus.ram_data, 0);
    chk("rst_cpu_ready", bus.cpu_ready, 0);
    chk("rst_ch_ready", bus.ch_ready, 0);
    chk("rst_busy", bus.busy, 1);
    chk("rst_cursor", {bus.cur_row, bus.cur_col}, 0);
    bus.cpu_valid = 1'b0;
    bus.ch_valid = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    wait_idle();
    chk("rst_clear_count", wq.size(), 750);
    chk_run("rst_clear_run", 0, 750, 8'h1F);
    chk("rst_done_busy", bus.busy, 0);
    chk("rst_done_cursor", {bus.cur_row, bus.cur_col}, 0);

    for (int i = 0; i < 11; i++) begin
      wq.delete();
      send_ch(tbl[i].ch);
      wait_idle();
      if (tbl[i].has_wr) pop_chk($sformatf("tbl%0d_wr", i), tbl[i].wa, tbl[i].wd);
      if (tbl[i].nclr > 0) chk_run($sformatf("tbl%0d_lclr", i), tbl[i].cbase, tbl[i].nclr, 8'h1F);
      chk($sformatf("tbl%0d_extra_wr", i), wq.size(), 0);
      chk($sformatf("tbl%0d_col", i), bus.cur_col, tbl[i].col);
      chk($sformatf("tbl%0d_row", i), bus.cur_row, tbl[i].row);
    end

    for (int i = 0; i < 12; i++) begin send_ch(8'h0A); wait_idle(); end
    for (int i = 0; i < 49; i++) begin send_ch(8'h2E); wait_idle(); end
    chk("corner_pre_cursor", {bus.cur_row, bus.cur_col}, {5'd14, 6'd49});
    wq.delete();
    tick();
    bus.ch_valid = 1'b1;
    bus.ch_data = 8'h78;
    #1;
    chk("corner_x_ready", bus.ch_ready, 1);
    tick();
    chk("corner_home", {bus.cur_row, bus.cur_col}, 0);
    bus.ch_data = 8'h79;
    #1;
    n = 0;
    while (!bus.ch_ready && n < 200) begin n++; tick(); end
    chk("corner_lclr_stall", n, 50);
    tick();
    bus.ch_valid = 1'b0;
    wait_idle();
    pop_chk("corner_x_wr", 12'd749, 16'h1F78);
    chk_run("corner_lclr", 0, 50, 8'h1F);
    pop_chk("corner_y_wr", 12'd0, 16'h1F79);
    chk("corner_post_cursor", {bus.cur_row, bus.cur_col}, {5'd0, 6'd1});

    wq.delete();
    tick();
    bus.cpu_valid = 1'b1;
    bus.cpu_addr = 12'd700;
    bus.cpu_data = 16'hABCD;
    bus.ch_valid = 1'b1;
    bus.ch_data = 8'h7A;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr%0d_cpu_ready", k), bus.cpu_ready, (k % 2 == 0));
      chk($sformatf("rr%0d_ch_ready", k), bus.ch_ready, (k % 2 == 1));
      if (k > 0) chk($sformatf("rr%0d_ram_ce", k), bus.ram_ce, 1);
      tick();
    end
    bus.cpu_valid = 1'b0;
    bus.ch_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) pop_chk($sformatf("rr%0d_wr", k), 12'd700, 16'hABCD);
      else pop_chk($sformatf("rr%0d_wr", k), 12'(1 + k / 2), 16'h1F7A);
    end
    chk("rr_cursor", {bus.cur_row, bus.cur_col}, {5'd0, 6'd5});

    send_ch(8'h0A);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_in_lclr", bus.busy, 1);
    bus.clr_req = 1'b1;
    #1;
    wq.delete();
    tick();
    bus.clr_req = 1'b0;
    wait_idle();
    if (wq.size() > 0 && wq[0].a >= 12'd50 && wq[0].a < 12'd100) void'(wq.pop_front());
    chk("abort_fclr_count", wq.size(), 750);
    chk_run("abort_fclr_run", 0, 750, 8'h1F);
    chk("abort_cursor", {bus.cur_row, bus.cur_col}, 0);

    bus.direction = 2'b01;
    #1;
    wq.delete();
    tick();
    wait_idle();
    chk("dir_fclr_count", wq.size(), 750);
    chk_run("dir_fclr_run", 0, 750, 8'h1F);
    chk("dir_cursor", {bus.cur_row, bus.cur_col}, 0);
    for (int i = 0; i < 31; i++) begin send_ch(8'(8'h41 + i % 26)); wait_idle(); end
    for (int i = 0; i < 30; i++) pop_chk($sformatf("dir_ch%0d", i), 12'(i), {8'h1F, 8'(8'h41 + i % 26)});
    chk_run("dir_lclr", 30, 30, 8'h1F);
    pop_chk("dir_ch30", 12'd30, {8'h1F, 8'h45});
    chk("dir_post_cursor", {bus.cur_row, bus.cur_col}, {5'd1, 6'd1});

    m_cols = 30;
    m_rows = 25;
    m_attr = 8'h2A;
    bus.attr = m_attr;
    send_ch(8'h0C);
    wait_idle();
    m_clear();
    for (int k = 0; k < 120; k++) begin
      if (k == 60) begin
        tick();
        bus.direction = 2'b10;
        tick();
        wait_idle();
        m_cols = 50;
        m_rows = 15;
        m_clear();
      end
      m_attr = 8'($urandom());
      bus.attr = m_attr;
      if ($urandom_range(0, 3) == 0) begin
        ra = 12'($urandom_range(0, 749));
        rd = 16'($urandom());
        cpu_wr(ra, rd);
        exp_scr[int'(ra)] = rd;
      end else begin
        sel = $urandom_range(0, 19);
        if (sel < 12) c = 8'($urandom_range(32, 126));
        else if (sel < 14) c = 8'h0A;
        else if (sel == 14) c = 8'h0D;
        else if (sel == 15) c = 8'h08;
        else if (sel == 16) c = 8'h7F;
        else if (sel == 17) c = 8'h1B;
        else if (sel == 18) c = 8'h00;
        else c = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h0D;
        send_ch(c);
        m_char(c);
      end
      wait_idle();
      chk($sformatf("rnd%0d_col", k), bus.cur_col, m_col);
      chk($sformatf("rnd%0d_row", k), bus.cur_row, m_row);
    end
    mism = 0;
    for (int i = 0; i < 750; i++) if (dut_scr[i] !== exp_scr[i]) mism++;
    chk("rnd_screen_image", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
